// File: rtl/mbist_fault_mem_if.sv
// Bus between an MBIST controller (master) and the fault-injecting memory model (slave).
// Handshake: en is a request that is always accepted on the rising edge; there is no ready or backpressure,
// and each accepted read returns exactly one rd_valid pulse, in order, READ_LATENCY cycles later.
interface mbist_fault_mem_if #(
    parameter int ROW_ADDR_BITS = 4,
    parameter int COL_ADDR_BITS = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_FAULTS    = 4
);
    localparam int IDX_W = (NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1;
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic                     en;
    logic                     wr_en;
    logic [ROW_ADDR_BITS-1:0] row;
    logic [COL_ADDR_BITS-1:0] col;
    logic [DATA_WIDTH-1:0]    data_in;
    logic [DATA_WIDTH-1:0]    data_out;
    logic                     rd_valid;
    logic                     flt_hit;
    logic                     flt_wr;
    logic [IDX_W-1:0]         flt_idx;
    logic [2:0]               flt_type;
    logic [ROW_ADDR_BITS-1:0] flt_row;
    logic [COL_ADDR_BITS-1:0] flt_col;
    logic [BIT_W-1:0]         flt_bit;

    modport master (
        output en, wr_en, row, col, data_in,
        output flt_wr, flt_idx, flt_type, flt_row, flt_col, flt_bit,
        input  data_out, rd_valid, flt_hit
    );

    modport slave (
        input  en, wr_en, row, col, data_in,
        input  flt_wr, flt_idx, flt_type, flt_row, flt_col, flt_bit,
        output data_out, rd_valid, flt_hit
    );
endinterface

// File: rtl/mbist_fault_mem.sv
// Single-port 2D memory model with a programmable fault table (stuck-at and transition faults)
// and a fixed-latency read pipeline, used as a known-faulty MBIST target.
module mbist_fault_mem #(
    parameter int ROW_ADDR_BITS = 4,
    parameter int COL_ADDR_BITS = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int READ_LATENCY  = 2,
    parameter int NUM_FAULTS    = 4
) (
    input logic               clk,
    input logic               rst_n,
    mbist_fault_mem_if.slave  mem_bus
);
    localparam int ADDR_W = ROW_ADDR_BITS + COL_ADDR_BITS;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [2:0] FT_NONE  = 3'd0;
    localparam logic [2:0] FT_SA0   = 3'd1;
    localparam logic [2:0] FT_SA1   = 3'd2;
    localparam logic [2:0] FT_TF_UP = 3'd3;
    localparam logic [2:0] FT_TF_DN = 3'd4;

    logic [DATA_WIDTH-1:0]    mem_q   [DEPTH];
    logic [2:0]               ftype_q [NUM_FAULTS];
    logic [ROW_ADDR_BITS-1:0] frow_q  [NUM_FAULTS];
    logic [COL_ADDR_BITS-1:0] fcol_q  [NUM_FAULTS];
    logic [BIT_W-1:0]         fbit_q  [NUM_FAULTS];

    logic [READ_LATENCY-1:0]  vld_q;
    logic [READ_LATENCY-1:0]  hit_q;
    logic [DATA_WIDTH-1:0]    data_q  [READ_LATENCY];

    logic [ADDR_W-1:0]        addr;
    logic                     rd_accept;
    logic                     wr_accept;
    logic [DATA_WIDTH-1:0]    old_word;
    logic [NUM_FAULTS-1:0]    slot_match;
    logic [DATA_WIDTH-1:0]    wr_word_d;
    logic [DATA_WIDTH-1:0]    rd_word_d;
    logic                     hit_d;

    assign addr      = {mem_bus.row, mem_bus.col};
    assign rd_accept = mem_bus.en & ~mem_bus.wr_en;
    assign wr_accept = mem_bus.en &  mem_bus.wr_en;
    assign old_word  = mem_q[addr];

    // A slot is live only with a fault type 1..4 and a bit index inside the word.
    always_comb begin
        slot_match = '0;
        for (int s = 0; s < NUM_FAULTS; s++) begin
            slot_match[s] = (ftype_q[s] >= FT_SA0) && (ftype_q[s] <= FT_TF_DN)
                            && (int'(fbit_q[s]) < DATA_WIDTH)
                            && (frow_q[s] == mem_bus.row) && (fcol_q[s] == mem_bus.col);
        end
    end

    assign hit_d = |slot_match;

    // Walk slots from highest to lowest so the lowest matching index decides each bit last.
    always_comb begin
        wr_word_d = mem_bus.data_in;
        rd_word_d = old_word;
        for (int s = NUM_FAULTS - 1; s >= 0; s--) begin
            if (slot_match[s]) begin
                case (ftype_q[s])
                    FT_SA0: begin
                        wr_word_d[fbit_q[s]] = 1'b0;
                        rd_word_d[fbit_q[s]] = 1'b0;
                    end
                    FT_SA1: begin
                        wr_word_d[fbit_q[s]] = 1'b1;
                        rd_word_d[fbit_q[s]] = 1'b1;
                    end
                    FT_TF_UP: begin
                        wr_word_d[fbit_q[s]] = mem_bus.data_in[fbit_q[s]] & old_word[fbit_q[s]];
                        rd_word_d[fbit_q[s]] = old_word[fbit_q[s]];
                    end
                    FT_TF_DN: begin
                        wr_word_d[fbit_q[s]] = mem_bus.data_in[fbit_q[s]] | old_word[fbit_q[s]];
                        rd_word_d[fbit_q[s]] = old_word[fbit_q[s]];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_accept) begin
            mem_q[addr] <= wr_word_d;
        end
    end

    // The table updates at the edge, so an access in the same cycle still sees the old slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_FAULTS; s++) begin
                ftype_q[s] <= FT_NONE;
                frow_q[s]  <= '0;
                fcol_q[s]  <= '0;
                fbit_q[s]  <= '0;
            end
        end else if (mem_bus.flt_wr && (int'(mem_bus.flt_idx) < NUM_FAULTS)) begin
            ftype_q[mem_bus.flt_idx] <= mem_bus.flt_type;
            frow_q[mem_bus.flt_idx]  <= mem_bus.flt_row;
            fcol_q[mem_bus.flt_idx]  <= mem_bus.flt_col;
            fbit_q[mem_bus.flt_idx]  <= mem_bus.flt_bit;
        end
    end

    // Data stages load only behind a valid stage, so the last stage holds its word between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            hit_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_accept;
            hit_q[0] <= rd_accept & hit_d;
            if (rd_accept) begin
                data_q[0] <= rd_word_d;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                hit_q[i] <= hit_q[i-1];
                if (vld_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign mem_bus.data_out = data_q[READ_LATENCY-1];
    assign mem_bus.rd_valid = vld_q[READ_LATENCY-1];
    assign mem_bus.flt_hit  = hit_q[READ_LATENCY-1];
endmodule

// File: tb/tb_mbist_fault_mem.sv
// Bench for mbist_fault_mem: three instances (latency 2, 1, 4) share one stimulus stream and
// one expected queue; each instance is checked for data, flt_hit and exact arrival cycle.
module tb_mbist_fault_mem;
    localparam int RB = 4;
    localparam int CB = 4;
    localparam int DW = 8;
    localparam int NF = 4;
    localparam int LAT [3] = '{2, 1, 4};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic          t_en = 1'b0, t_wr_en = 1'b0, t_fwr = 1'b0;
    logic [RB-1:0] t_row = '0, t_frow = '0;
    logic [CB-1:0] t_col = '0, t_fcol = '0;
    logic [DW-1:0] t_din = '0;
    logic [1:0]    t_fidx = '0;
    logic [2:0]    t_ftype = '0, t_fbit = '0;

    mbist_fault_mem_if #(.ROW_ADDR_BITS(RB), .COL_ADDR_BITS(CB), .DATA_WIDTH(DW), .NUM_FAULTS(NF)) bus0 ();
    mbist_fault_mem_if #(.ROW_ADDR_BITS(RB), .COL_ADDR_BITS(CB), .DATA_WIDTH(DW), .NUM_FAULTS(NF)) bus1 ();
    mbist_fault_mem_if #(.ROW_ADDR_BITS(RB), .COL_ADDR_BITS(CB), .DATA_WIDTH(DW), .NUM_FAULTS(NF)) bus2 ();

    assign {bus0.en, bus0.wr_en, bus0.row, bus0.col, bus0.data_in, bus0.flt_wr, bus0.flt_idx, bus0.flt_type, bus0.flt_row, bus0.flt_col, bus0.flt_bit}
         = {t_en, t_wr_en, t_row, t_col, t_din, t_fwr, t_fidx, t_ftype, t_frow, t_fcol, t_fbit};
    assign {bus1.en, bus1.wr_en, bus1.row, bus1.col, bus1.data_in, bus1.flt_wr, bus1.flt_idx, bus1.flt_type, bus1.flt_row, bus1.flt_col, bus1.flt_bit}
         = {t_en, t_wr_en, t_row, t_col, t_din, t_fwr, t_fidx, t_ftype, t_frow, t_fcol, t_fbit};
    assign {bus2.en, bus2.wr_en, bus2.row, bus2.col, bus2.data_in, bus2.flt_wr, bus2.flt_idx, bus2.flt_type, bus2.flt_row, bus2.flt_col, bus2.flt_bit}
         = {t_en, t_wr_en, t_row, t_col, t_din, t_fwr, t_fidx, t_ftype, t_frow, t_fcol, t_fbit};

    mbist_fault_mem #(.ROW_ADDR_BITS(RB), .COL_ADDR_BITS(CB), .DATA_WIDTH(DW), .READ_LATENCY(LAT[0]), .NUM_FAULTS(NF))
        dut_l2 (.clk(clk), .rst_n(rst_n), .mem_bus(bus0));
    mbist_fault_mem #(.ROW_ADDR_BITS(RB), .COL_ADDR_BITS(CB), .DATA_WIDTH(DW), .READ_LATENCY(LAT[1]), .NUM_FAULTS(NF))
        dut_l1 (.clk(clk), .rst_n(rst_n), .mem_bus(bus1));
    mbist_fault_mem #(.ROW_ADDR_BITS(RB), .COL_ADDR_BITS(CB), .DATA_WIDTH(DW), .READ_LATENCY(LAT[2]), .NUM_FAULTS(NF))
        dut_l4 (.clk(clk), .rst_n(rst_n), .mem_bus(bus2));

    logic [DW-1:0] o_dout [3];
    logic          o_vld  [3];
    logic          o_hit  [3];
    assign o_dout[0] = bus0.data_out; assign o_vld[0] = bus0.rd_valid; assign o_hit[0] = bus0.flt_hit;
    assign o_dout[1] = bus1.data_out; assign o_vld[1] = bus1.rd_valid; assign o_hit[1] = bus1.flt_hit;
    assign o_dout[2] = bus2.data_out; assign o_vld[2] = bus2.rd_valid; assign o_hit[2] = bus2.flt_hit;

    // Scoreboard: one entry per issued read, shared by all instances through per-instance pointers.
    logic [DW-1:0] exp_q     [$];
    logic          exp_hit_q [$];
    int            exp_cyc_q [$];
    int            rd_ptr    [3] = '{0, 0, 0};

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (o_vld[k] === 1'b1) begin
                checks++;
                if (rd_ptr[k] >= exp_q.size()) begin
                    errors++;
                    $display("FAIL unexpected_rd_valid lat=%0d cyc=%0d data_out=%h", LAT[k], cyc, o_dout[k]);
                end else begin
                    if (o_dout[k] !== exp_q[rd_ptr[k]] || o_hit[k] !== exp_hit_q[rd_ptr[k]]
                        || cyc !== exp_cyc_q[rd_ptr[k]] + LAT[k]) begin
                        errors++;
                        $display("FAIL read_result lat=%0d got data=%h hit=%b cyc=%0d expected data=%h hit=%b cyc=%0d",
                                 LAT[k], o_dout[k], o_hit[k], cyc, exp_q[rd_ptr[k]], exp_hit_q[rd_ptr[k]],
                                 exp_cyc_q[rd_ptr[k]] + LAT[k]);
                    end
                    rd_ptr[k]++;
                end
            end else if (rd_ptr[k] < exp_q.size() && cyc > exp_cyc_q[rd_ptr[k]] + LAT[k]) begin
                checks++;
                errors++;
                $display("FAIL missing_rd_valid lat=%0d cyc=%0d rd_valid=%b expected data=%h", LAT[k], cyc,
                         o_vld[k], exp_q[rd_ptr[k]]);
                rd_ptr[k]++;
            end
        end
        while (exp_q.size() > 0 && rd_ptr[0] > 0 && rd_ptr[1] > 0 && rd_ptr[2] > 0) begin
            void'(exp_q.pop_front());
            void'(exp_hit_q.pop_front());
            void'(exp_cyc_q.pop_front());
            for (int k = 0; k < 3; k++) rd_ptr[k]--;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            t_en = 1'b0; t_wr_en = 1'b0; t_fwr = 1'b0;
        end
    endtask

    task automatic do_write(input logic [RB-1:0] r, input logic [CB-1:0] c, input logic [DW-1:0] d);
        @(negedge clk);
        t_en = 1'b1; t_wr_en = 1'b1; t_row = r; t_col = c; t_din = d; t_fwr = 1'b0;
    endtask

    task automatic do_read(input logic [RB-1:0] r, input logic [CB-1:0] c, input logic [DW-1:0] exp_d,
                           input logic exp_h);
        @(negedge clk);
        t_en = 1'b1; t_wr_en = 1'b0; t_row = r; t_col = c; t_fwr = 1'b0;
        exp_q.push_back(exp_d);
        exp_hit_q.push_back(exp_h);
        exp_cyc_q.push_back(cyc);
    endtask

    task automatic prog(input logic [1:0] idx, input logic [2:0] ftype, input logic [RB-1:0] r,
                        input logic [CB-1:0] c, input logic [2:0] b);
        @(negedge clk);
        t_en = 1'b0; t_wr_en = 1'b0;
        t_fwr = 1'b1; t_fidx = idx; t_ftype = ftype; t_frow = r; t_fcol = c; t_fbit = b;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 50) begin
            @(negedge clk);
            t_en = 1'b0; t_wr_en = 1'b0; t_fwr = 1'b0;
            budget++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
            exp_q.delete(); exp_hit_q.delete(); exp_cyc_q.delete();
            rd_ptr = '{0, 0, 0};
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        t_en = 1'b0; t_wr_en = 1'b0; t_fwr = 1'b0;
        exp_q.delete(); exp_hit_q.delete(); exp_cyc_q.delete();
        rd_ptr = '{0, 0, 0};
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o_vld[k] !== 1'b0 || o_dout[k] !== '0 || o_hit[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs lat=%0d got vld=%b data=%h hit=%b expected 0 00 0", LAT[k],
                         o_vld[k], o_dout[k], o_hit[k]);
            end
        end
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        idle(3);
    endtask

    task automatic test_clean_walk();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) do_write(RB'(r), CB'(c), DW'(r * 16 + c));
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) do_read(RB'(r), CB'(c), DW'(r * 16 + c), 1'b0);
        drain();
    endtask

    task automatic test_stuck_at();
        apply_reset();
        prog(2'd0, 3'd2, 4'd3, 4'd5, 3'd2);
        prog(2'd1, 3'd1, 4'd3, 4'd5, 3'd7);
        do_read(4'd3, 4'd5, 8'h04, 1'b1);
        do_read(4'd3, 4'd4, 8'h00, 1'b0);
        do_write(4'd3, 4'd5, 8'hFF);
        do_read(4'd3, 4'd5, 8'h7F, 1'b1);
        prog(2'd0, 3'd0, 4'd3, 4'd5, 3'd2);
        prog(2'd1, 3'd0, 4'd3, 4'd5, 3'd7);
        do_read(4'd3, 4'd5, 8'h7F, 1'b0);
        drain();
    endtask

    task automatic test_transition();
        prog(2'd2, 3'd3, 4'd0, 4'd0, 3'd0);
        do_write(4'd0, 4'd0, 8'h00);
        do_write(4'd0, 4'd0, 8'h01);
        do_read(4'd0, 4'd0, 8'h00, 1'b1);
        prog(2'd2, 3'd4, 4'd0, 4'd0, 3'd0);
        do_write(4'd0, 4'd0, 8'h01);
        do_write(4'd0, 4'd0, 8'h00);
        do_read(4'd0, 4'd0, 8'h01, 1'b1);
        prog(2'd2, 3'd5, 4'd0, 4'd0, 3'd0);
        do_write(4'd0, 4'd0, 8'h00);
        do_read(4'd0, 4'd0, 8'h00, 1'b0);
        drain();
    endtask

    task automatic test_precedence();
        prog(2'd0, 3'd1, 4'd1, 4'd1, 3'd4);
        prog(2'd3, 3'd2, 4'd1, 4'd1, 3'd4);
        do_write(4'd1, 4'd1, 8'h10);
        do_read(4'd1, 4'd1, 8'h00, 1'b1);
        prog(2'd0, 3'd0, 4'd1, 4'd1, 3'd4);
        do_read(4'd1, 4'd1, 8'h10, 1'b1);
        prog(2'd3, 3'd0, 4'd1, 4'd1, 3'd4);
        do_read(4'd1, 4'd1, 8'h00, 1'b0);
        drain();
    endtask

    task automatic test_concurrent_prog();
        @(negedge clk);
        t_en = 1'b1; t_wr_en = 1'b0; t_row = 4'd2; t_col = 4'd2;
        t_fwr = 1'b1; t_fidx = 2'd1; t_ftype = 3'd2; t_frow = 4'd2; t_fcol = 4'd2; t_fbit = 3'd0;
        exp_q.push_back(8'h00); exp_hit_q.push_back(1'b0); exp_cyc_q.push_back(cyc);
        do_read(4'd2, 4'd2, 8'h01, 1'b1);
        prog(2'd1, 3'd0, 4'd2, 4'd2, 3'd0);
        drain();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] vals [8];
        logic [DW-1:0] d;
        for (int i = 0; i < 8; i++) begin
            vals[i] = DW'($urandom_range(0, 255));
            do_write(4'd7, CB'(i), vals[i]);
        end
        for (int i = 0; i < 8; i++) do_read(4'd7, CB'(i), vals[i], 1'b0);
        d = DW'($urandom_range(1, 255));
        do_write(4'd9, 4'd9, d);
        do_read(4'd9, 4'd9, d, 1'b0);
        drain();
    endtask

    task automatic test_reset_mid_flight();
        do_write(4'd4, 4'd0, 8'hA5);
        do_write(4'd4, 4'd1, 8'h5A);
        do_write(4'd4, 4'd2, 8'h3C);
        do_read(4'd4, 4'd0, 8'hA5, 1'b0);
        do_read(4'd4, 4'd1, 8'h5A, 1'b0);
        do_read(4'd4, 4'd2, 8'h3C, 1'b0);
        apply_reset();
        idle(8);
        do_read(4'd4, 4'd0, 8'h00, 1'b0);
        do_read(4'd4, 4'd2, 8'h00, 1'b0);
        drain();
    endtask

    initial begin
        test_reset();
        test_clean_walk();
        test_stuck_at();
        test_transition();
        test_precedence();
        test_concurrent_prog();
        test_back_to_back();
        test_reset_mid_flight();
        idle(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout cyc=%0d expected completion", cyc);
        $fatal(1, "simulation did not complete");
    end
endmodule

// File: doc/mbist_fault_mem.md
# mbist_fault_mem

Parametrised 2D single-port memory model with configurable read latency and a programmable fault table. It injects stuck-at and transition faults into selected cells. It replaces the plain behavioural array as the MBIST target, so march-algorithm controllers and comparators can be exercised against known-faulty cells in simulation.

## Interface
- ROW_ADDR_BITS, 4, row address width; 2**ROW_ADDR_BITS rows
- COL_ADDR_BITS, 4, column address width; 2**COL_ADDR_BITS columns
- DATA_WIDTH, 8, word width in bits
- READ_LATENCY, 2, cycles from accepted read to rd_valid; legal 1..4
- NUM_FAULTS, 4, number of fault-table slots; legal 1..16

- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  access request this cycle
- wr_en  in  1  with en: 1 = write, 0 = read
- row  in  ROW_ADDR_BITS  row address
- col  in  COL_ADDR_BITS  column address
- data_in  in  DATA_WIDTH  write data
- data_out  out  DATA_WIDTH  read data; valid when rd_valid
- rd_valid  out  1  read data strobe, one cycle per accepted read
- flt_hit  out  1  aligned with rd_valid: an active fault targets the read cell
- flt_wr  in  1  program fault slot this cycle
- flt_idx  in  $clog2(NUM_FAULTS) (min 1)  slot index; values >= NUM_FAULTS ignored
- flt_type  in  3  0 none, 1 SA0, 2 SA1, 3 TF_UP (0->1 fails), 4 TF_DN (1->0 fails), 5-7 treated as none
- flt_row / flt_col  in  ROW_ADDR_BITS / COL_ADDR_BITS  faulty cell
- flt_bit  in  $clog2(DATA_WIDTH) (min 1)  faulty bit; >= DATA_WIDTH makes the slot inert

## Operation
- Reset: every cell cleared to 0; all fault slots set to type 0; read pipeline flushed; data_out = 0, rd_valid = 0, flt_hit = 0.
- Write (en & wr_en): stored word = data_in after fault modification of the target cell's bits.
  - SA0 forces the bit to 0; SA1 forces it to 1.
  - TF_UP: old 0 and new 1 -> bit stays 0.
  - TF_DN: old 1 and new 0 -> bit stays 1.
- Read (en & !wr_en): raw word is sampled from the array in the accept cycle. SA0/SA1 are re-applied on the read path, so an SA1 cell reads 1 even straight after reset. Transition faults affect writes only.
- Fault precedence: when several active slots target the same bit, the lowest slot index wins. Different bits of one word are faulted independently.
- flt_hit = 1 if any active slot (type 1-4, legal flt_bit) matches the read row/col, whether or not data changed.
- Fault programming: flt_wr writes slot flt_idx on the clock edge. It is independent of en and may coincide with an access. The new slot affects only accesses accepted in later cycles.
- Reprogramming a slot to type 0 removes the fault. Data already stored in the array is not repaired.
- en = 0: no array change; pipeline advances and shifts in an invalid stage.

## Timing
- Write: array updated at the accept edge. A read accepted in the next cycle returns the new word.
- Read: accepted at edge N. data_out, rd_valid and flt_hit are registered outputs valid in the cycle after edge N+READ_LATENCY-1, i.e. READ_LATENCY cycles after the accepting edge.
- Back-to-back reads: one accepted per cycle; rd_valid pulses consecutively in order; no stalls, no backpressure.
- Interleaved write then read to the same cell on consecutive cycles: the read returns the written (fault-modified) value.
- data_out holds its last value when rd_valid = 0.
- Asynchronous reset mid-operation: in-flight reads are discarded and no rd_valid is produced. Array and fault table are cleared immediately.

## Test plan
- Clean walk: default params, write row r col c with {r,c} to all 256 cells, then read all. Each rd_valid arrives 2 cycles after its request with data_out = {r,c} and flt_hit = 0.
- Stuck-at: slot0 = SA1 at (3,5) bit 2, slot1 = SA0 at (3,5) bit 7.
  - Read (3,5) after reset -> 0x04, flt_hit = 1.
  - Write 0xFF, read -> 0x7F.
- Transition: slot2 = TF_UP at (0,0) bit 0. Write 0x00, write 0x01, read -> 0x00. Reprogram slot2 = TF_DN, write 0x01, write 0x00, read -> 0x01.
- Precedence/overlap: slot0 = SA0 and slot3 = SA1 on the same bit (1,1) bit 4. Read after writing 0x10 -> 0x00. Clear slot0, then read (1,1) again without rewriting -> 0x10.
- Latency sweep: READ_LATENCY = 1 and 4, 8 back-to-back reads. rd_valid is asserted for exactly 8 consecutive cycles starting 1 or 4 cycles after the first request, and data is in order.
- Reset mid-flight: issue 3 reads, assert rst_n low 1 cycle later. No rd_valid follows, data_out = 0, and a subsequent read of any cell returns 0.
